trap_ctrl: RTL and testbench

//  M-mode trap sequencer for the rv32 core. It arbitrates synchronous exceptions and the MSI/MTI/MEI lines.
//  It owns the trap CSRs: mstatus MIE/MPIE/MPP, mie, mip, mtvec, mepc, mcause and mtval.
//  It sequences trap entry and mret, then hands the core a redirect PC through a valid/ready flush handshake.

---
 rtl/trap_ctrl_pkg.sv | 44 ++++
 rtl/trap_ctrl_irq_arb.sv | 26 ++
 rtl/trap_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the M-mode trap sequencer.
package trap_ctrl_pkg;

  typedef enum logic [1:0] {
    PrivU = 2'b00,
    PrivM = 2'b11
  } priv_mode_t;

  typedef enum logic [1:0] {
    StIdle,
    StEnter,
    StRedirect
  } trap_state_t;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;

  localparam int unsigned MSIP = 3;
  localparam int unsigned MTIP = 7;
  localparam int unsigned MEIP = 11;

  localparam logic [4:0] TRAP_CODE_MSI = 5'd3;
  localparam logic [4:0] TRAP_CODE_MTI = 5'd7;
  localparam logic [4:0] TRAP_CODE_MEI = 5'd11;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSTATUSH = 12'h310;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  // Spread {mei, mti, msi} onto the architectural mip/mie bit positions.
  function automatic logic [31:0] irq_bits(logic [2:0] b);
    return {20'b0, b[2], 3'b0, b[1], 3'b0, b[0], 3'b0};
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_arb.sv
// Interrupt pending/enable qualification and fixed-priority selection (MEI > MSI > MTI).
module trap_irq_arb
  import trap_ctrl_pkg::*;
(
  input  logic [2:0] pend_i,        // {mei, mti, msi}
  input  logic [2:0] en_i,          // {mei, mti, msi}
  input  priv_mode_t priv_i,
  input  logic       mstatus_mie_i,
  output logic       irq_take_o,
  output logic [4:0] irq_code_o
);

  logic [2:0] act;

  always_comb begin
    act        = pend_i & en_i;
    irq_take_o = (act != 3'b000) && ((priv_i == PrivU) || mstatus_mie_i);
    irq_code_o = TRAP_CODE_MTI;
    if (act[2]) begin
      irq_code_o = TRAP_CODE_MEI;
    end else if (act[0]) begin
      irq_code_o = TRAP_CODE_MSI;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// M-mode trap sequencer: trap CSRs, event arbitration, trap entry / mret and redirect handshake.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_tval,
  input  logic [31:0] cur_pc,
  input  logic        mret,
  input  logic        irq_msi,
  input  logic        irq_mti,
  input  logic        irq_mei,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_hit,
  output logic        busy,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic [1:0]  priv
);

  localparam logic [31:0] MtvecRst =
      VECTORED_EN ? MTVEC_RESET : {MTVEC_RESET[31:2], MTVEC_MODE_DIRECT};

  trap_state_t state_q, state_d;
  priv_mode_t  priv_q, priv_d, mpp_q, mpp_d;
  logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [2:0]  mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        lat_irq_q, lat_irq_d;
  logic [4:0]  lat_code_q, lat_code_d;
  logic [31:0] lat_tval_q, lat_tval_d, lat_pc_q, lat_pc_d;

  logic [2:0]  pend;
  logic        irq_take;
  logic [4:0]  irq_code;
  logic [31:0] vec_base;

  assign pend = {irq_mei, irq_mti, irq_msi};

  trap_irq_arb u_irq_arb (
    .pend_i        (pend),
    .en_i          (mie_q),
    .priv_i        (priv_q),
    .mstatus_mie_i (mst_mie_q),
    .irq_take_o    (irq_take),
    .irq_code_o    (irq_code)
  );

  assign vec_base       = {mtvec_q[31:2], 2'b00};
  assign busy           = (state_q != StIdle);
  assign redirect_valid = (state_q == StRedirect);
  assign redirect_pc    = redirect_pc_q;
  assign priv           = priv_q;

  always_comb begin
    state_d       = state_q;
    priv_d        = priv_q;
    mpp_d         = mpp_q;
    mst_mie_d     = mst_mie_q;
    mst_mpie_d    = mst_mpie_q;
    mie_d         = mie_q;
    mtvec_d       = mtvec_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    redirect_pc_d = redirect_pc_q;
    lat_irq_d     = lat_irq_q;
    lat_code_d    = lat_code_q;
    lat_tval_d    = lat_tval_q;
    lat_pc_d      = lat_pc_q;

    // CSR writes land first; trap/mret updates below override the fields they own.
    if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mst_mie_d  = csr_wdata[MSTATUS_MIE];
          mst_mpie_d = csr_wdata[MSTATUS_MPIE];
          if (csr_wdata[MSTATUS_MPP_LO +: 2] == PrivU) mpp_d = PrivU;
          if (csr_wdata[MSTATUS_MPP_LO +: 2] == PrivM) mpp_d = PrivM;
        end
        CSR_MIE:    mie_d = {csr_wdata[MEIP], csr_wdata[MTIP], csr_wdata[MSIP]};
        CSR_MTVEC: begin
          mtvec_d[31:2] = csr_wdata[31:2];
          if ((csr_wdata[1:0] == MTVEC_MODE_DIRECT) ||
              ((csr_wdata[1:0] == MTVEC_MODE_VECTORED) && VECTORED_EN)) begin
            mtvec_d[1:0] = csr_wdata[1:0];
          end
        end
        CSR_MEPC:   mepc_d   = {csr_wdata[31:2], 2'b00};
        CSR_MCAUSE: mcause_d = csr_wdata;
        CSR_MTVAL:  mtval_d  = csr_wdata;
        default: ;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (exc_valid) begin
          lat_irq_d  = 1'b0;
          lat_code_d = exc_code;
          lat_tval_d = exc_tval;
          lat_pc_d   = cur_pc;
          state_d    = StEnter;
        end else if (irq_take) begin
          lat_irq_d  = 1'b1;
          lat_code_d = irq_code;
          lat_tval_d = 32'h0;
          lat_pc_d   = cur_pc;
          state_d    = StEnter;
        end else if (mret) begin
          mst_mie_d     = mst_mpie_d;
          mst_mpie_d    = 1'b1;
          priv_d        = mpp_d;
          mpp_d         = PrivU;
          redirect_pc_d = mepc_d;
          state_d       = StRedirect;
        end
      end
      StEnter: begin
        mepc_d     = {lat_pc_q[31:2], 2'b00};
        mcause_d   = {lat_irq_q, 26'b0, lat_code_q};
        mtval_d    = lat_tval_q;
        mst_mpie_d = mst_mie_q;
        mst_mie_d  = 1'b0;
        mpp_d      = priv_q;
        priv_d     = PrivM;
        if (lat_irq_q && (mtvec_q[1:0] == MTVEC_MODE_VECTORED)) begin
          redirect_pc_d = vec_base + {25'b0, lat_code_q, 2'b00};
        end else begin
          redirect_pc_d = vec_base;
        end
        state_d = StRedirect;
      end
      StRedirect: begin
        if (redirect_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    csr_hit   = 1'b1;
    csr_rdata = 32'h0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE]         = mst_mie_q;
        csr_rdata[MSTATUS_MPIE]        = mst_mpie_q;
        csr_rdata[MSTATUS_MPP_LO +: 2] = mpp_q;
      end
      CSR_MIE:      csr_rdata = irq_bits(mie_q);
      CSR_MTVEC:    csr_rdata = mtvec_q;
      CSR_MSTATUSH: csr_rdata = 32'h0;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_MCAUSE:   csr_rdata = mcause_q;
      CSR_MTVAL:    csr_rdata = mtval_q;
      CSR_MIP:      csr_rdata = irq_bits(pend);
      default:      csr_hit   = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      priv_q        <= PrivM;
      mpp_q         <= PrivM;
      mst_mie_q     <= 1'b0;
      mst_mpie_q    <= 1'b0;
      mie_q         <= 3'b000;
      mtvec_q       <= MtvecRst;
      mepc_q        <= 32'h0;
      mcause_q      <= 32'h0;
      mtval_q       <= 32'h0;
      redirect_pc_q <= 32'h0;
      lat_irq_q     <= 1'b0;
      lat_code_q    <= 5'h0;
      lat_tval_q    <= 32'h0;
      lat_pc_q      <= 32'h0;
    end else begin
      state_q       <= state_d;
      priv_q        <= priv_d;
      mpp_q         <= mpp_d;
      mst_mie_q     <= mst_mie_d;
      mst_mpie_q    <= mst_mpie_d;
      mie_q         <= mie_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      redirect_pc_q <= redirect_pc_d;
      lat_irq_q     <= lat_irq_d;
      lat_code_q    <= lat_code_d;
      lat_tval_q    <= lat_tval_d;
      lat_pc_q      <= lat_pc_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: cycle model checked every cycle plus hand-computed literals.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_tval = '0;
  logic [31:0] cur_pc = '0;
  logic        mret = 1'b0;
  logic        irq_msi = 1'b0, irq_mti = 1'b0, irq_mei = 1'b0;
  logic [11:0] csr_addr = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        busy;
  logic        redirect_valid;
  logic        redirect_ready = 1'b0;
  logic [31:0] redirect_pc;
  logic [1:0]  priv;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  trap_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .exc_tval       (exc_tval),
    .cur_pc         (cur_pc),
    .mret           (mret),
    .irq_msi        (irq_msi),
    .irq_mti        (irq_mti),
    .irq_mei        (irq_mei),
    .csr_addr       (csr_addr),
    .csr_we         (csr_we),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .csr_hit        (csr_hit),
    .busy           (busy),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .priv           (priv)
  );

  always #50 clk = ~clk;

  // Architectural model: stage 0 = waiting for events, 1 = trap being entered, 2 = redirect offered.
  typedef struct {
    int          stage;
    logic [1:0]  priv;
    logic        mie_bit;
    logic        mpie;
    logic [1:0]  mpp;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] rpc;
    logic        t_irq;
    int          t_code;
    logic [31:0] t_tval;
    logic [31:0] t_pc;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.stage = 0; r.priv = 2'b11; r.mie_bit = 0; r.mpie = 0; r.mpp = 2'b11;
    r.mie = 0; r.mtvec = 0; r.mepc = 0; r.mcause = 0; r.mtval = 0; r.rpc = 0;
    r.t_irq = 0; r.t_code = 0; r.t_tval = 0; r.t_pc = 0;
    return r;
  endfunction

  function automatic logic [31:0] mip_word(logic msi, logic mti, logic mei);
    return (32'(mei) << 11) | (32'(mti) << 7) | (32'(msi) << 3);
  endfunction

  // Returns {hit, data}.
  function automatic logic [32:0] model_read(model_t s, logic [11:0] a, logic [31:0] mipv);
    case (a)
      12'h300: return {1'b1, 19'b0, s.mpp, 3'b0, s.mpie, 3'b0, s.mie_bit, 3'b0};
      12'h304: return {1'b1, s.mie};
      12'h305: return {1'b1, s.mtvec};
      12'h310: return {1'b1, 32'h0};
      12'h341: return {1'b1, s.mepc};
      12'h342: return {1'b1, s.mcause};
      12'h343: return {1'b1, s.mtval};
      12'h344: return {1'b1, mipv};
      default: return 33'h0;
    endcase
  endfunction

  initial m = model_reset();

  always @(posedge clk) begin
    model_t n;
    logic [31:0] act;
    logic [31:0] base;
    n = m;
    if (!rst_n) begin
      n = model_reset();
    end else begin
      if (csr_we) begin
        case (csr_addr)
          12'h300: begin
            n.mie_bit = csr_wdata[3];
            n.mpie    = csr_wdata[7];
            if (csr_wdata[12:11] == 2'b00 || csr_wdata[12:11] == 2'b11) n.mpp = csr_wdata[12:11];
          end
          12'h304: n.mie = csr_wdata & 32'h888;
          12'h305: begin
            n.mtvec = {csr_wdata[31:2], m.mtvec[1:0]};
            if (csr_wdata[1:0] <= 2'b01) n.mtvec[1:0] = csr_wdata[1:0];
          end
          12'h341: n.mepc   = csr_wdata & ~32'h3;
          12'h342: n.mcause = csr_wdata;
          12'h343: n.mtval  = csr_wdata;
          default: ;
        endcase
      end
      if (m.stage == 0) begin
        act = mip_word(irq_msi, irq_mti, irq_mei) & m.mie;
        if (exc_valid) begin
          n.t_irq = 0; n.t_code = int'(exc_code); n.t_tval = exc_tval; n.t_pc = cur_pc;
          n.stage = 1;
        end else if (act != 0 && (m.priv == 2'b00 || m.mie_bit)) begin
          n.t_irq = 1; n.t_tval = 0; n.t_pc = cur_pc;
          n.t_code = act[11] ? 11 : (act[3] ? 3 : 7);
          n.stage = 1;
        end else if (mret) begin
          n.mie_bit = n.mpie;
          n.mpie    = 1'b1;
          n.priv    = n.mpp;
          n.mpp     = 2'b00;
          n.rpc     = n.mepc;
          n.stage   = 2;
        end
      end else if (m.stage == 1) begin
        n.mepc    = m.t_pc & ~32'h3;
        n.mcause  = (32'(m.t_irq) << 31) | 32'(m.t_code);
        n.mtval   = m.t_tval;
        n.mpie    = m.mie_bit;
        n.mie_bit = 1'b0;
        n.mpp     = m.priv;
        n.priv    = 2'b11;
        base      = m.mtvec & ~32'h3;
        n.rpc     = (m.t_irq && m.mtvec[1:0] == 2'b01) ? base + 32'(4 * m.t_code) : base;
        n.stage   = 2;
      end else if (redirect_ready) begin
        n.stage = 0;
      end
    end
    m <= n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] rd;
    if (chk_en) begin
      rd = model_read(m, csr_addr, mip_word(irq_msi, irq_mti, irq_mei));
      check("cyc_busy", 32'(busy), 32'(m.stage != 0));
      check("cyc_redirect_valid", 32'(redirect_valid), 32'(m.stage == 2));
      check("cyc_redirect_pc", redirect_pc, m.rpc);
      check("cyc_priv", 32'(priv), 32'(m.priv));
      check("cyc_csr_hit", 32'(csr_hit), 32'(rd[32]));
      check("cyc_csr_rdata", csr_rdata, rd[31:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_addr = a; csr_wdata = d; csr_we = 1'b1;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic csr_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    check(name, csr_rdata, exp);
  endtask

  task automatic accept();
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_priv", 32'(priv), 32'h3);
    csr_chk("rst_mstatus", 12'h300, 32'h1800);
    csr_chk("rst_mtvec", 12'h305, 32'h0);

    // Direct-mode exception with MIE=1 beforehand.
    csr_write(12'h305, 32'h100);
    csr_write(12'h300, 32'h8);
    exc_valid = 1'b1; exc_code = 5'd2; exc_tval = 32'hDEAD; cur_pc = 32'h2004;
    tick();
    exc_valid = 1'b0; cur_pc = 32'h0;
    check("exc_not_yet_valid", 32'(redirect_valid), 32'h0);
    check("exc_busy", 32'(busy), 32'h1);
    tick();
    check("exc_redirect_valid", 32'(redirect_valid), 32'h1);
    check("exc_redirect_pc", redirect_pc, 32'h100);
    csr_chk("exc_mepc", 12'h341, 32'h2004);
    csr_chk("exc_mcause", 12'h342, 32'h2);
    csr_chk("exc_mtval", 12'h343, 32'hDEAD);
    csr_chk("exc_mstatus", 12'h300, 32'h1880);
    accept();
    check("exc_done_busy", 32'(busy), 32'h0);

    // mret to user mode.
    csr_write(12'h300, 32'h80);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    check("mret_redirect_valid", 32'(redirect_valid), 32'h1);
    check("mret_redirect_pc", redirect_pc, 32'h2004);
    check("mret_priv", 32'(priv), 32'h0);
    csr_chk("mret_mstatus", 12'h300, 32'h88);
    accept();

    // User mode, MIE=0, vectored MTI still traps.
    csr_write(12'h300, 32'h80);
    csr_write(12'h304, 32'h80);
    csr_write(12'h305, 32'h201);
    irq_mti = 1'b1;
    tick();
    tick();
    check("mti_redirect_pc", redirect_pc, 32'h21C);
    check("mti_priv", 32'(priv), 32'h3);
    csr_chk("mti_mcause", 12'h342, 32'h8000_0007);
    csr_chk("mti_mtval", 12'h343, 32'h0);
    csr_chk("mti_mstatus", 12'h300, 32'h0);
    irq_mti = 1'b0;
    accept();

    // Exception beats MEI; then stall the handshake with an ignored exception pulse.
    csr_write(12'h304, 32'h888);
    csr_write(12'h300, 32'h1808);
    irq_mei = 1'b1;
    exc_valid = 1'b1; exc_code = 5'd5; exc_tval = 32'h55; cur_pc = 32'h3000;
    tick();
    exc_valid = 1'b0;
    tick();
    csr_chk("prio_mcause", 12'h342, 32'h5);
    for (int i = 0; i < 5; i++) begin
      exc_valid = (i == 1);
      exc_code  = 5'd4;
      tick();
      check("hold_valid", 32'(redirect_valid), 32'h1);
      check("hold_pc", redirect_pc, 32'h200);
      check("hold_busy", 32'(busy), 32'h1);
    end
    exc_valid = 1'b0;
    csr_chk("hold_mcause", 12'h342, 32'h5);
    accept();
    check("hold_done_busy", 32'(busy), 32'h0);

    // MSI and MEI together: MEI wins, vectored to base + 44.
    irq_msi = 1'b1;
    csr_write(12'h300, 32'h1808);
    tick();
    tick();
    check("irq_prio_pc", redirect_pc, 32'h22C);
    csr_chk("irq_prio_mcause", 12'h342, 32'h8000_000B);
    irq_msi = 1'b0; irq_mei = 1'b0;
    accept();

    // WARL fields and read-only / unmapped addresses.
    csr_write(12'h305, 32'h100);
    csr_write(12'h305, 32'h302);
    csr_chk("warl_mtvec", 12'h305, 32'h300);
    csr_write(12'h300, 32'h800);
    csr_chk("warl_mpp", 12'h300, 32'h1800);
    csr_write(12'h341, 32'h1237);
    csr_chk("warl_mepc", 12'h341, 32'h1234);
    csr_write(12'h344, 32'hFFFF_FFFF);
    irq_mti = 1'b1;
    csr_chk("mip_live", 12'h344, 32'h80);
    irq_mti = 1'b0;
    csr_chk("mstatush", 12'h310, 32'h0);
    csr_addr = 12'h7C0;
    #1;
    check("unknown_hit", 32'(csr_hit), 32'h0);
    check("unknown_rdata", csr_rdata, 32'h0);
    tick();

    // Reset while entering a trap.
    exc_valid = 1'b1; exc_code = 5'd2; exc_tval = 32'h77; cur_pc = 32'h4000;
    tick();
    exc_valid = 1'b0;
    check("rst_mid_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_valid", 32'(redirect_valid), 32'h0);
    check("rst_mid_pc", redirect_pc, 32'h0);
    csr_chk("rst_mid_mepc", 12'h341, 32'h0);
    csr_chk("rst_mid_mtvec", 12'h305, 32'h0);
    csr_chk("rst_mid_mcause", 12'h342, 32'h0);
    csr_chk("rst_mid_mie", 12'h304, 32'h0);
    tick();
    tick();
    check("rst_mid_stays_idle", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
